// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch sequencer. Issues one instruction-memory
//                request per retired instruction, holds the fetched word for
//                the decoder and advances the PC sequentially or by a
//                conditional word-offset branch. Records sticky errors for
//                memory timeouts and for retire pulses with no instruction
//                in hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_pc,
    input  logic [2:0]  br_op,
    input  logic        flag_neg,
    input  logic        flag_zero,
    input  logic [31:0] br_off,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  func,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic        upd_err
);

    // Wait counter only needs to reach IMEM_TIMEOUT, where it saturates.
    localparam int                 C_CNT_W   = (IMEM_TIMEOUT < 1) ? 1 : $clog2(IMEM_TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(IMEM_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                uerr_q, uerr_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic                taken;
    logic [31:0]         pc_seq;
    logic [31:0]         pc_br;

    // Branch decision; codes 100-111 never branch.
    always_comb begin
        taken = 1'b0;
        case (br_op)
            3'b000:  taken = 1'b1;
            3'b001:  taken = flag_neg;
            3'b010:  taken = ~flag_neg;
            3'b011:  taken = flag_zero;
            default: taken = 1'b0;
        endcase
    end

    // Candidate next PCs; the offset is in words, and arithmetic wraps mod 2^32.
    always_comb begin
        pc_seq = pc_q + 32'd4;
        pc_br  = pc_seq + (br_off << 2);
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        uerr_d  = uerr_q;
        cnt_d   = '0;

        case (state_q)
            IDLE: begin
                // Any ack seen here belongs to an aborted fetch and is dropped.
                state_d = REQ;
                if (upd_pc) begin
                    uerr_d = 1'b1;
                end
            end
            REQ: begin
                if (upd_pc) begin
                    uerr_d = 1'b1;
                end
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (upd_pc) begin
                    uerr_d = 1'b1;
                end
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    // Timeout only flags the condition; the request stays up.
                    cnt_d = (cnt_q == C_TIMEOUT) ? cnt_q : cnt_q + 1'b1;
                    if (cnt_d == C_TIMEOUT) begin
                        ferr_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (upd_pc) begin
                    pc_d    = taken ? pc_br : pc_seq;
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            uerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            uerr_q  <= uerr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = (state_q == REQ) || (state_q == WAIT);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign func        = instr_q[4:0];
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign fetch_err   = ferr_q;
    assign upd_err     = uerr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit: a table of
//                fetch/retire steps plus hand sequences for timeout, reset
//                abort and illegal retire pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        upd_pc;
    logic [2:0]  br_op;
    logic        flag_neg;
    logic        flag_zero;
    logic [31:0] br_off;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  func;
    logic [31:0] pc;
    logic        instr_valid;
    logic        fetch_err;
    logic        upd_err;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC     (RESET_PC),
        .IMEM_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_pc      (upd_pc),
        .br_op       (br_op),
        .flag_neg    (flag_neg),
        .flag_zero   (flag_zero),
        .br_off      (br_off),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .func        (func),
        .pc          (pc),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err),
        .upd_err     (upd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        neg;
        logic        zero;
        logic [31:0] off;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic [2:0] op, input logic neg, input logic zero,
                                input logic [31:0] off, input logic [31:0] exp_pc);
        vec_t v;
        v.op     = op;
        v.neg    = neg;
        v.zero   = zero;
        v.off    = off;
        v.exp_pc = exp_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Deliver one instruction word; state must already be REQ or WAIT.
    task automatic fetch(input logic [31:0] rd, input logic [31:0] exp_addr);
        chk("req_before_ack", {31'b0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = rd;
        tick();
        imem_ack   = 1'b0;
        chk("instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("instr", instr, rd);
        chk("opcode", {26'b0, opcode}, {26'b0, rd[31:26]});
        chk("func", {27'b0, func}, {27'b0, rd[4:0]});
        chk("req_in_hold", {31'b0, imem_req}, 32'd0);
    endtask

    task automatic retire(input logic [2:0] op, input logic neg, input logic zero,
                          input logic [31:0] off, input logic [31:0] exp_pc);
        upd_pc    = 1'b1;
        br_op     = op;
        flag_neg  = neg;
        flag_zero = zero;
        br_off    = off;
        tick();
        upd_pc    = 1'b0;
        chk("pc", pc, exp_pc);
        chk("valid_cleared", {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_errs", {30'b0, fetch_err, upd_err}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("idle_req", {31'b0, imem_req}, 32'd0);
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_pc;

        rst        = 1'b1;
        upd_pc     = 1'b0;
        br_op      = 3'b000;
        flag_neg   = 1'b0;
        flag_zero  = 1'b0;
        br_off     = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;

        vecs[0]  = mk(3'b000, 1'b0, 1'b0, 32'd3,          32'h0000_0010);
        vecs[1]  = mk(3'b100, 1'b0, 1'b0, 32'd5,          32'h0000_0014);
        vecs[2]  = mk(3'b000, 1'b0, 1'b0, 32'd2,          32'h0000_0020);
        vecs[3]  = mk(3'b001, 1'b1, 1'b0, 32'hFFFF_FFFD,  32'h0000_0018);
        vecs[4]  = mk(3'b000, 1'b0, 1'b0, 32'd1,          32'h0000_0020);
        vecs[5]  = mk(3'b001, 1'b0, 1'b0, 32'hFFFF_FFFD,  32'h0000_0024);
        vecs[6]  = mk(3'b000, 1'b0, 1'b0, 32'hFFFF_FFFE,  32'h0000_0020);
        vecs[7]  = mk(3'b011, 1'b0, 1'b1, 32'd2,          32'h0000_002C);
        vecs[8]  = mk(3'b010, 1'b0, 1'b0, 32'd1,          32'h0000_0034);
        vecs[9]  = mk(3'b010, 1'b1, 1'b0, 32'd1,          32'h0000_0038);
        vecs[10] = mk(3'b011, 1'b0, 1'b0, 32'd4,          32'h0000_003C);
        vecs[11] = mk(3'b111, 1'b1, 1'b1, 32'd4,          32'h0000_0040);
        vecs[12] = mk(3'b000, 1'b0, 1'b0, 32'hFFFF_FFEE,  32'hFFFF_FFFC);
        vecs[13] = mk(3'b101, 1'b1, 1'b1, 32'd0,          32'h0000_0000);
        vecs[14] = mk(3'b110, 1'b0, 1'b1, 32'd7,          32'h0000_0004);

        apply_reset();

        // Table: fetch at the expected PC, idle a HOLD cycle with a stray ack,
        // then retire and compare the new PC.
        exp_pc = RESET_PC;
        for (int i = 0; i < 15; i++) begin
            rd = (i == 0) ? 32'h0400_0003 : 32'h0400_0003 + i * 32'h0C00_0011;
            fetch(rd, exp_pc);
            imem_ack   = 1'b1;
            imem_rdata = ~rd;
            tick();
            imem_ack   = 1'b0;
            chk("hold_instr_stable", instr, rd);
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            retire(vecs[i].op, vecs[i].neg, vecs[i].zero, vecs[i].off, vecs[i].exp_pc);
            chk("no_errs", {30'b0, fetch_err, upd_err}, 32'd0);
            exp_pc = vecs[i].exp_pc;
        end
        chk("first_opcode_table", {26'b0, 6'b000001}, {26'b0, vecs[0].exp_pc[31:26] | 6'b000001});

        // Timeout: ack withheld 20 cycles from REQ at pc=4.
        for (int t = 1; t <= 20; t++) begin
            tick();
            chk("to_req", {31'b0, imem_req}, 32'd1);
            chk("to_addr", imem_addr, 32'h0000_0004);
            chk("to_ferr", {31'b0, fetch_err}, (t - 1 >= 16) ? 32'd1 : 32'd0);
        end
        fetch(32'hDEAD_BEEF, 32'h0000_0004);
        chk("to_ferr_sticky", {31'b0, fetch_err}, 32'd1);
        retire(3'b100, 1'b0, 1'b0, 32'd0, 32'h0000_0008);
        chk("to_ferr_after_retire", {31'b0, fetch_err}, 32'd1);
        chk("to_uerr", {31'b0, upd_err}, 32'd0);

        // Illegal retire in WAIT, then reset while waiting.
        apply_reset();
        chk("post_rst_ferr", {31'b0, fetch_err}, 32'd0);
        tick();
        tick();
        upd_pc = 1'b1;
        br_op  = 3'b000;
        br_off = 32'd9;
        tick();
        upd_pc = 1'b0;
        chk("wait_uerr", {31'b0, upd_err}, 32'd1);
        chk("wait_pc_kept", pc, RESET_PC);
        chk("wait_req_kept", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_req", {31'b0, imem_req}, 32'd0);
        chk("abort_pc", pc, RESET_PC);
        chk("abort_uerr", {31'b0, upd_err}, 32'd0);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        rst = 1'b0;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'd0);
        chk("late_ack_req", {31'b0, imem_req}, 32'd1);
        fetch(32'hFC00_001F, RESET_PC);
        retire(3'b011, 1'b0, 1'b1, 32'd1, 32'h0000_0008);
        chk("final_errs", {30'b0, fetch_err, upd_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter IMEM_TIMEOUT, default 16, max cycles waiting for imem_ack before raising fetch_err.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port upd_pc  input  1  one-cycle "instruction retired, advance PC" pulse from control_unit.
REQ-006 SHALL have port br_op  input  3  branch condition: 000 always, 001 neg, 010 not-neg, 011 zero, 100-111 never.
REQ-007 SHALL have ports flag_neg, flag_zero  input  1 each  ALU status flags for the retiring instruction.
REQ-008 SHALL have port br_off  input  32  signed word offset for branch instructions.
REQ-009 SHALL have ports imem_req  output  1, imem_addr  output  32, imem_ack  input  1, imem_rdata  input  32  instruction memory handshake.
REQ-010 SHALL have ports instr  output  32, opcode  output  6 (instr[31:26]), func  output  5 (instr[4:0]), pc  output  32.
REQ-011 SHALL have ports instr_valid  output  1, fetch_err  output  1 (sticky), upd_err  output  1 (sticky).

Function
REQ-012 SHALL implement states IDLE, REQ, WAIT, HOLD.
REQ-013 SHALL move IDLE -> REQ one cycle after rst deasserts.
REQ-014 SHALL, in REQ and WAIT, drive imem_req=1 and imem_addr=pc, both held stable until imem_ack=1 is sampled.
REQ-015 SHALL go REQ -> WAIT if imem_ack=0, and REQ or WAIT -> HOLD on the edge where imem_ack=1 is sampled.
REQ-016 SHALL, on that same edge, latch imem_rdata into instr; instr_valid goes 1 the following cycle; imem_req goes 0 in HOLD.
REQ-017 SHALL derive opcode and func combinationally from the latched instr; instr shall stay stable throughout HOLD.
REQ-018 SHALL, in HOLD on upd_pc=1, compute taken = (br_op==000) | (br_op==001 & flag_neg) | (br_op==010 & !flag_neg) | (br_op==011 & flag_zero).
REQ-019 SHALL load pc <= taken ? pc+4+(br_off<<2) : pc+4, with modulo-2^32 wrap and no overflow flag.
REQ-020 SHALL, on that same upd_pc edge, clear instr_valid and go HOLD -> REQ, so the next request issues one cycle after upd_pc.
REQ-021 SHALL ignore upd_pc in IDLE, REQ and WAIT, leaving pc unchanged, and set upd_err=1.
REQ-022 SHALL ignore imem_ack whenever imem_req=0.
REQ-023 SHALL count wait cycles in WAIT and set fetch_err=1 once the count reaches IMEM_TIMEOUT.
REQ-024 SHALL keep waiting after fetch_err is set; the request is not abandoned.
REQ-025 SHALL treat br_op codes 100-111 as not taken (sequential PC+4).

Reset
REQ-026 SHALL, while rst=1, immediately force state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_err=0, upd_err=0, and wait count=0.
REQ-027 SHALL abort any outstanding fetch on a mid-operation reset; an imem_ack arriving during or after rst in IDLE is ignored.
REQ-028 SHALL clear fetch_err and upd_err only by rst.

Verification
REQ-029 Bench SHALL check: rst release, imem_ack on the first REQ cycle, rdata=32'h0400_0003 -> imem_addr=0, instr_valid=1 next cycle, opcode=6'b000001, func=5'b00011.
REQ-030 Bench SHALL check: in HOLD with pc=0x10, upd_pc with br_op=100 -> pc=0x14; a new imem_req with addr 0x14 one cycle later.
REQ-031 Bench SHALL check conditional branches:
  - pc=0x20, br_off=-3, br_op=001, flag_neg=1 -> pc=0x18.
  - Same with flag_neg=0 -> pc=0x24.
  - br_op=011, flag_zero=1, br_off=2 -> pc=0x2C.
REQ-032 Bench SHALL check: pc=32'hFFFF_FFFC, sequential upd_pc -> pc=0, no error flags.
REQ-033 Bench SHALL check: imem_ack held low for 20 cycles -> imem_req/imem_addr stable throughout, fetch_err=1 after 16 WAIT cycles, normal completion on the late ack.
REQ-034 Bench SHALL check the reset and error paths:
  - rst asserted in WAIT -> imem_req=0 immediately, pc=RESET_PC; an ack one cycle later is ignored.
  - upd_pc pulsed in WAIT -> upd_err=1, pc unchanged.
